// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter and pending-write scoreboard for the 32x32 register file.
//   Three producers (0 = ALU, 1 = load unit, 2 = mul/div) share the single
//   register-file write port. One producer is granted per cycle in round-robin
//   order and its write is presented to the register file from a registered
//   stage. A pending-write vector lets decode stall on RAW/WAW hazards.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   ReqValid[2:0]                   producer i has a write pending
//   ReqReg[14:0]                    destination of producer i at [5i+4:5i]
//   ReqData[95:0]                   data of producer i at [32i+31:32i]
//   ReqReady[2:0]                   one-hot grant (combinational)
//   IssueValid, IssueReg            decode issues an instruction writing IssueReg
//   LookupReg1/2, Busy1/2           source-register pending lookups (combinational)
//   RegWrite, WriteRegister,
//   WriteData                       registered register-file write port
//   Err                             sticky protocol-error flag
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int NREQ   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        ReqValid,
  input  logic [NREQ*REG_W-1:0]  ReqReg,
  input  logic [NREQ*DATA_W-1:0] ReqData,
  output logic [NREQ-1:0]        ReqReady,
  input  logic                   IssueValid,
  input  logic [REG_W-1:0]       IssueReg,
  input  logic [REG_W-1:0]       LookupReg1,
  input  logic [REG_W-1:0]       LookupReg2,
  output logic                   Busy1,
  output logic                   Busy2,
  output logic                   RegWrite,
  output logic [REG_W-1:0]       WriteRegister,
  output logic [DATA_W-1:0]      WriteData,
  output logic                   Err
);

  localparam int NREGS = 1 << REG_W;

  // Last granted requester; reset to 2 so requester 0 is searched first.
  logic [1:0]       last;
  logic [NREQ-1:0]  grant;
  logic [1:0]       grantIdx;
  logic             grantAny;
  logic [REG_W-1:0] selReg;
  logic [DATA_W-1:0] selData;

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pendingNext;
  logic             wawIssue;
  logic             orphanCommit;

  // (base + step) mod 3, for the round-robin search order.
  function automatic logic [1:0] wrapAdd(input logic [1:0] base, input int unsigned step);
    int unsigned sum;
    sum = int'(base) + step;
    return 2'((sum % 3));
  endfunction

  // Search order Last+1, Last+2, Last; the first valid requester wins.
  always_comb begin
    logic [1:0] cand;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant    = '0;
    grantIdx = last;
    grantAny = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = wrapAdd(last, k);
      if (!grantAny && ReqValid[cand]) begin
        grant[cand] = 1'b1;
        grantIdx    = cand;
        grantAny    = 1'b1;
      end
    end
  end

  // Gate the grant with reset so no producer believes it transferred while
  // the block is held in reset.
  assign ReqReady = rst_n ? grant : '0;

  assign selReg  = ReqReg[grantIdx*REG_W +: REG_W];
  assign selData = ReqData[grantIdx*DATA_W +: DATA_W];

  // Scoreboard: the commit edge clears, an issue on the same edge sets, and
  // the set is applied last so it wins. Register 0 never becomes pending.
  always_comb begin
    pendingNext = pending;
    if (RegWrite) pendingNext[WriteRegister] = 1'b0;
    if (IssueValid && (IssueReg != '0)) pendingNext[IssueReg] = 1'b1;
    pendingNext[0] = 1'b0;
  end

  // A WAW issue is only an error if the target is not committing this edge.
  assign wawIssue     = IssueValid && (IssueReg != '0) && pending[IssueReg] &&
                        !(RegWrite && (WriteRegister == IssueReg));
  assign orphanCommit = RegWrite && !pending[WriteRegister];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last          <= 2'd2;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      pending       <= '0;
      Err           <= 1'b0;
    end else begin
      pending <= pendingNext;
      if (wawIssue || orphanCommit) Err <= 1'b1;
      if (grantAny) begin
        last          <= grantIdx;
        // A write to r0 still transfers and latches, but never enables the port.
        RegWrite      <= (selReg != '0);
        WriteRegister <= selReg;
        WriteData     <= selData;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  assign Busy1 = pending[LookupReg1];
  assign Busy2 = pending[LookupReg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized phase, all compared against a behavioural model of the arbiter,
// scoreboard and register file.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ReqValid;
  logic [14:0] ReqReg;
  logic [95:0] ReqData;
  logic [2:0]  ReqReady;
  logic        IssueValid;
  logic [4:0]  IssueReg;
  logic [4:0]  LookupReg1;
  logic [4:0]  LookupReg2;
  logic        Busy1;
  logic        Busy2;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Err;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ReqValid     (ReqValid),
    .ReqReg       (ReqReg),
    .ReqData      (ReqData),
    .ReqReady     (ReqReady),
    .IssueValid   (IssueValid),
    .IssueReg     (IssueReg),
    .LookupReg1   (LookupReg1),
    .LookupReg2   (LookupReg2),
    .Busy1        (Busy1),
    .Busy2        (Busy2),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .Err          (Err)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT's write port (r0 hardwired to zero).
  logic [31:0] tbRf [32];
  initial for (int i = 0; i < 32; i++) tbRf[i] = '0;
  always @(posedge clk) if (RegWrite && WriteRegister != 0) tbRf[WriteRegister] <= WriteData;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  int          mLast;
  bit          mRw;
  bit [4:0]    mWreg;
  bit [31:0]   mWdata;
  bit          mPend [32];
  bit          mErr;
  bit [31:0]   mRf [32];
  bit [2:0]    mXfer;

  // Values observed in the most recent step, for directed checks.
  logic [2:0]  seenReady;
  logic        seenRw;
  logic [4:0]  seenWreg;
  logic [31:0] seenWdata;
  logic        seenBusy1;
  logic        seenErr;

  function automatic int modelGrant();
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (mLast + k) % 3;
      if (ReqValid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mLast = 2; mRw = 0; mWreg = 0; mWdata = 0; mErr = 0; mXfer = 0;
    for (int i = 0; i < 32; i++) mPend[i] = 0;
  endtask

  task automatic clearInputs();
    ReqValid = 0; ReqReg = 0; ReqData = 0;
    IssueValid = 0; IssueReg = 0; LookupReg1 = 0; LookupReg2 = 0;
  endtask

  // Called at a negedge with inputs already driven: compare, advance the
  // model across the coming posedge, and move to the next negedge.
  task automatic step();
    int g;
    #1;
    g = modelGrant();
    check("ReqReady", ReqReady, (g < 0) ? 32'd0 : (32'd1 << g));
    check("RegWrite", RegWrite, mRw);
    check("WriteRegister", WriteRegister, mWreg);
    check("WriteData", WriteData, mWdata);
    check("Err", Err, mErr);
    check("Busy1", Busy1, mPend[LookupReg1]);
    check("Busy2", Busy2, mPend[LookupReg2]);
    seenReady = ReqReady; seenRw = RegWrite; seenWreg = WriteRegister;
    seenWdata = WriteData; seenBusy1 = Busy1; seenErr = Err;

    if (IssueValid && IssueReg != 0 && mPend[IssueReg] && !(mRw && mWreg == IssueReg)) mErr = 1;
    if (mRw && !mPend[mWreg]) mErr = 1;
    if (mRw) begin
      mRf[mWreg]   = mWdata;
      mPend[mWreg] = 0;
    end
    if (IssueValid && IssueReg != 0) mPend[IssueReg] = 1;
    mXfer = 0;
    if (g >= 0) begin
      mXfer[g] = 1;
      mLast    = g;
      mWreg    = ReqReg[g*5 +: 5];
      mWdata   = ReqData[g*32 +: 32];
      mRw      = (mWreg != 0);
    end else begin
      mRw = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 0;
    #1;
    check("rst_ReqReady", ReqReady, 0);
    check("rst_RegWrite", RegWrite, 0);
    check("rst_Err", Err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    modelReset();
  endtask

  // Randomized producer state.
  bit [4:0]  pReg [3];
  bit [31:0] pData [3];
  bit        pValid [3];
  int        freeRegs [$];

  logic [2:0] readyExp [6];
  logic       rwExp [6];

  initial begin
    for (int i = 0; i < 32; i++) mRf[i] = 0;
    modelReset();
    clearInputs();

    // Reset with every producer valid, then four round-robin grants.
    ReqValid = 3'b111;
    ReqReg   = {5'd3, 5'd2, 5'd1};
    ReqData  = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    doReset();
    readyExp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
    rwExp    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      if (c == 4) ReqValid = 3'b000;
      step();
      check($sformatf("rr_ready_%0d", c), seenReady, readyExp[c]);
      check($sformatf("rr_rw_%0d", c), seenRw, rwExp[c]);
    end

    // Issue r5, load unit writes r5 = DEADBEEF.
    clearInputs();
    doReset();
    LookupReg1 = 5;
    IssueValid = 1; IssueReg = 5;
    step();
    IssueValid = 0;
    ReqValid = 3'b010; ReqReg[9:5] = 5; ReqData[63:32] = 32'hDEAD_BEEF;
    step();
    check("r5_busy_before_xfer", seenBusy1, 1);
    ReqValid = 0;
    step();
    check("r5_busy_commit_cycle", seenBusy1, 1);
    check("r5_wdata", seenWdata, 32'hDEAD_BEEF);
    step();
    check("r5_busy_after", seenBusy1, 0);
    check("r5_rf", tbRf[5], mRf[5]);
    check("r5_rf_value", tbRf[5], 32'hDEAD_BEEF);

    // ALU writes r0: transfer completes, no write enable, no error.
    ReqValid = 3'b001; ReqReg[4:0] = 0; ReqData[31:0] = 32'h1234;
    step();
    check("r0_grant", seenReady, 3'b001);
    ReqValid = 0;
    step();
    check("r0_rw", seenRw, 0);
    check("r0_wreg", seenWreg, 0);
    check("r0_wdata", seenWdata, 32'h1234);
    check("r0_err", seenErr, 0);

    // Issue r7 on the edge r7 commits: set wins, no error.
    LookupReg1 = 7;
    IssueValid = 1; IssueReg = 7;
    step();
    IssueValid = 0;
    ReqValid = 3'b001; ReqReg[4:0] = 7; ReqData[31:0] = 32'h7777_0001;
    step();
    ReqValid = 0;
    IssueValid = 1; IssueReg = 7;
    step();
    check("r7_commit_rw", seenRw, 1);
    IssueValid = 0;
    step();
    check("r7_busy_kept", seenBusy1, 1);
    check("r7_err", seenErr, 0);
    ReqValid = 3'b001; ReqData[31:0] = 32'h7777_0002;
    step();
    ReqValid = 0;
    step();
    step();
    check("r7_busy_cleared", seenBusy1, 0);

    // Randomized traffic that obeys the hazard rules.
    clearInputs();
    doReset();
    for (int i = 0; i < 3; i++) pValid[i] = 0;
    freeRegs.delete();
    for (int c = 0; c < 400; c++) begin
      int r;
      for (int i = 0; i < 3; i++) begin
        if (mXfer[i]) pValid[i] = 0;
        if (!pValid[i] && $urandom_range(0, 2) != 0) begin
          if (freeRegs.size() > 0) begin
            pReg[i] = 5'(freeRegs.pop_front());
            pValid[i] = 1;
            pData[i] = $urandom;
          end else if ($urandom_range(0, 9) == 0) begin
            pReg[i] = 0;
            pValid[i] = 1;
            pData[i] = $urandom;
          end
        end
        ReqValid[i] = pValid[i];
        ReqReg[i*5 +: 5] = pReg[i];
        ReqData[i*32 +: 32] = pData[i];
      end
      IssueValid = 0;
      IssueReg = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        r = int'(IssueReg);
        if (r == 0) IssueValid = 1;
        else if (!mPend[r]) begin
          IssueValid = 1;
          freeRegs.push_back(r);
        end
      end
      LookupReg1 = 5'($urandom_range(0, 31));
      LookupReg2 = 5'($urandom_range(0, 31));
      step();
    end
    ReqValid = 0; IssueValid = 0;
    step();
    step();
    for (int i = 1; i < 32; i++) check($sformatf("rf_r%0d", i), tbRf[i], mRf[i]);

    // Issue r9 twice with no commit: sticky error.
    clearInputs();
    doReset();
    IssueValid = 1; IssueReg = 9;
    step();
    step();
    IssueValid = 0;
    step();
    check("r9_err_set", seenErr, 1);
    step();
    step();
    check("r9_err_sticky", seenErr, 1);

    // Wrap-around grant to requester 2, then reset mid-transfer.
    doReset();
    LookupReg1 = 12;
    IssueValid = 1; IssueReg = 12;
    step();
    IssueValid = 0;
    ReqValid = 3'b100; ReqReg[14:10] = 12; ReqData[95:64] = 32'h5A5A_1212;
    step();
    check("wrap_grant", seenReady, 3'b100);
    ReqValid = 0;
    #1;
    check("inflight_rw", RegWrite, 1);
    rst_n = 0;
    #1;
    check("async_rw", RegWrite, 0);
    check("async_wreg", WriteRegister, 0);
    check("async_wdata", WriteData, 0);
    check("async_busy", Busy1, 0);
    @(posedge clk);
    @(negedge clk);
    check("dropped_write", tbRf[12], mRf[12]);
    check("dropped_rw", RegWrite, 0);
    rst_n = 1;
    modelReset();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
